// File: rtl/spu_dual_issue_pkg.sv
// Shared types, opcode constants and opcode classification for the SPU issue stage.
package spu_dual_issue_pkg;

  localparam int REG_W = 7;
  localparam int INS_W = 57;

  typedef logic [10:0] opcode_t;

  localparam opcode_t OPC_NOP  = 11'h201;
  localparam opcode_t OPC_LNOP = 11'h001;
  localparam opcode_t OPC_A    = 11'h0C0;
  localparam opcode_t OPC_AND  = 11'h0C1;
  localparam opcode_t OPC_SHL  = 11'h05B;
  localparam opcode_t OPC_ROT  = 11'h058;
  localparam opcode_t OPC_FA   = 11'h2C4;
  localparam opcode_t OPC_FM   = 11'h2C6;
  localparam opcode_t OPC_LQD  = 11'h1A0;
  localparam opcode_t OPC_STQD = 11'h120;
  localparam opcode_t OPC_BR   = 11'h190;

  typedef enum logic {PIPE_EVEN, PIPE_ODD} pipe_t;

  typedef enum logic [1:0] {EMPTY, PAIR, SECOND} issue_state_t;

  typedef logic [2:0] lat_t;

  // Pre-decoded instruction word, MSB first.
  typedef struct packed {
    opcode_t          opcode;
    logic [17:0]      i18;
    logic [REG_W-1:0] ra;
    logic [REG_W-1:0] rb;
    logic [REG_W-1:0] rc;
    logic [REG_W-1:0] rt;
  } ins_t;

  // Loads, stores and branches use the odd pipe; everything else is even.
  function automatic pipe_t opcode_pipe(input opcode_t opc);
    case (opc)
      OPC_LQD, OPC_STQD, OPC_BR, OPC_LNOP: return PIPE_ODD;
      default:                             return PIPE_EVEN;
    endcase
  endfunction

  // Cycles from issue until a dependent may issue.
  function automatic lat_t opcode_latency(input opcode_t opc);
    case (opc)
      OPC_A, OPC_AND:    return 3'd2;
      OPC_SHL, OPC_ROT:  return 3'd4;
      OPC_FA, OPC_FM:    return 3'd6;
      OPC_LQD, OPC_STQD: return 3'd6;
      OPC_BR:            return 3'd1;
      OPC_NOP, OPC_LNOP: return 3'd1;
      default:           return 3'd2;
    endcase
  endfunction

endpackage

// File: rtl/spu_dual_issue_scoreboard.sv
// Per-register latency counters: two load ports from issue, six source lookups and
// two write-after-write lookups against a per-instruction threshold.
module spu_dual_issue_scoreboard
  import spu_dual_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld0_en,
  input  logic [REG_W-1:0] ld0_addr,
  input  logic [LAT_W-1:0] ld0_cnt,
  input  logic             ld1_en,
  input  logic [REG_W-1:0] ld1_addr,
  input  logic [LAT_W-1:0] ld1_cnt,
  input  logic [REG_W-1:0] src_addr [6],
  output logic [5:0]       src_busy,
  input  logic [REG_W-1:0] waw_addr [2],
  input  logic [LAT_W-1:0] waw_thr  [2],
  output logic [1:0]       waw_busy
);

  logic [LAT_W-1:0] cnt [NUM_REGS];

  // Load on issue, otherwise count down towards zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!rst)
        cnt[i] <= '0;
      else if (ld0_en && ld0_addr == REG_W'(i))
        cnt[i] <= ld0_cnt;
      else if (ld1_en && ld1_addr == REG_W'(i))
        cnt[i] <= ld1_cnt;
      else if (cnt[i] != '0)
        cnt[i] <= cnt[i] - LAT_W'(1);
    end
  end

  // Lookups see the pre-edge counts.
  always_comb begin
    src_busy = '0;
    waw_busy = '0;
    for (int k = 0; k < 6; k++) src_busy[k] = (cnt[src_addr[k]] != '0);
    for (int k = 0; k < 2; k++) waw_busy[k] = (cnt[waw_addr[k]] > waw_thr[k]);
  end

endmodule

// File: rtl/spu_dual_issue.sv
// Dual-issue stage: holds one instruction pair, issues in order to the even/odd pipes.
// Optional performance counters are built when SPU_ISSUE_PERF_EN is defined.
module spu_dual_issue
  import spu_dual_issue_pkg::*;
#(
  parameter int NUM_REGS = 128,
  parameter int LAT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [INS_W-1:0] in_ins0,
  input  logic [INS_W-1:0] in_ins1,
  input  logic             flush,
  output opcode_t          opcode_ep,
  output opcode_t          opcode_op,
  output logic [REG_W-1:0] ra_addr_ep,
  output logic [REG_W-1:0] rb_addr_ep,
  output logic [REG_W-1:0] rc_addr_ep,
  output logic [REG_W-1:0] rt_addr_ep,
  output logic [REG_W-1:0] ra_addr_op,
  output logic [REG_W-1:0] rb_addr_op,
  output logic [REG_W-1:0] rc_addr_op,
  output logic [REG_W-1:0] rt_addr_op,
  output logic [6:0]       in_I7e,
  output logic [7:0]       in_I8e,
  output logic [9:0]       in_I10e,
  output logic [15:0]      in_I16e,
  output logic [17:0]      in_I18e,
  output logic [6:0]       in_I7o,
  output logic [7:0]       in_I8o,
  output logic [9:0]       in_I10o,
  output logic [15:0]      in_I16o,
  output logic [17:0]      in_I18o,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      split_cnt
);

  issue_state_t     state, state_nxt;
  ins_t             ins0_q, ins1_q;
  pipe_t            pipe0, pipe1;
  lat_t             lat0, lat1;
  logic [REG_W-1:0] src_addr [6];
  logic [5:0]       src_busy;
  logic [REG_W-1:0] waw_addr [2];
  logic [LAT_W-1:0] waw_thr  [2];
  logic [1:0]       waw_busy;
  logic             ready0, ready1, hazard;
  logic             iss0, iss1, accept;
  logic             iss_even, iss_odd;
  ins_t             ins_even, ins_odd;

  // Classify the held pair and form scoreboard lookups.
  always_comb begin
    pipe0       = opcode_pipe(ins0_q.opcode);
    pipe1       = opcode_pipe(ins1_q.opcode);
    lat0        = opcode_latency(ins0_q.opcode);
    lat1        = opcode_latency(ins1_q.opcode);
    src_addr[0] = ins0_q.ra;
    src_addr[1] = ins0_q.rb;
    src_addr[2] = ins0_q.rc;
    src_addr[3] = ins1_q.ra;
    src_addr[4] = ins1_q.rb;
    src_addr[5] = ins1_q.rc;
    waw_addr[0] = ins0_q.rt;
    waw_addr[1] = ins1_q.rt;
    waw_thr[0]  = LAT_W'(lat0 - lat_t'(1));
    waw_thr[1]  = LAT_W'(lat1 - lat_t'(1));
    ready0      = ~|src_busy[2:0] && !waw_busy[0];
    ready1      = ~|src_busy[5:3] && !waw_busy[1];
    hazard      = (ins1_q.ra == ins0_q.rt) || (ins1_q.rb == ins0_q.rt) ||
                  (ins1_q.rc == ins0_q.rt) || (ins1_q.rt == ins0_q.rt);
  end

  spu_dual_issue_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .LAT_W    (LAT_W)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .ld0_en   (iss0),
    .ld0_addr (ins0_q.rt),
    .ld0_cnt  (waw_thr[0]),
    .ld1_en   (iss1),
    .ld1_addr (ins1_q.rt),
    .ld1_cnt  (waw_thr[1]),
    .src_addr (src_addr),
    .src_busy (src_busy),
    .waw_addr (waw_addr),
    .waw_thr  (waw_thr),
    .waw_busy (waw_busy)
  );

  // Issue decision and next state; a new pair is taken only once the held one fully drains.
  always_comb begin
    iss0      = 1'b0;
    iss1      = 1'b0;
    in_ready  = 1'b0;
    state_nxt = state;
    case (state)
      EMPTY: begin
        in_ready = !flush;
        if (in_valid && in_ready) state_nxt = PAIR;
      end
      PAIR: begin
        iss0 = ready0 && !flush;
        iss1 = iss0 && (pipe0 != pipe1) && ready1 && !hazard;
        if (iss1) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? PAIR : EMPTY;
        end else if (iss0) begin
          state_nxt = SECOND;
        end
      end
      SECOND: begin
        iss1 = ready1 && !flush;
        if (iss1) begin
          in_ready  = 1'b1;
          state_nxt = in_valid ? PAIR : EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    if (flush) state_nxt = EMPTY;
    accept = in_valid && in_ready;
  end

  // Steer each issuing slot to the pipe its opcode belongs to.
  always_comb begin
    iss_even = 1'b0;
    iss_odd  = 1'b0;
    ins_even = ins0_q;
    ins_odd  = ins1_q;
    if (iss0) begin
      if (pipe0 == PIPE_EVEN) begin iss_even = 1'b1; ins_even = ins0_q; end
      else                    begin iss_odd  = 1'b1; ins_odd  = ins0_q; end
    end
    if (iss1) begin
      if (pipe1 == PIPE_EVEN) begin iss_even = 1'b1; ins_even = ins1_q; end
      else                    begin iss_odd  = 1'b1; ins_odd  = ins1_q; end
    end
  end

  // State register and held pair.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= EMPTY;
      ins0_q <= '0;
      ins1_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        ins0_q <= ins_t'(in_ins0);
        ins1_q <= ins_t'(in_ins1);
      end
    end
  end

  // Registered pipe fields; an idle pipe gets its NOP while fields hold.
  always_ff @(posedge clk) begin
    if (!rst) begin
      opcode_ep  <= OPC_NOP;
      opcode_op  <= OPC_LNOP;
      ra_addr_ep <= '0; rb_addr_ep <= '0; rc_addr_ep <= '0; rt_addr_ep <= '0;
      ra_addr_op <= '0; rb_addr_op <= '0; rc_addr_op <= '0; rt_addr_op <= '0;
      in_I7e <= '0; in_I8e <= '0; in_I10e <= '0; in_I16e <= '0; in_I18e <= '0;
      in_I7o <= '0; in_I8o <= '0; in_I10o <= '0; in_I16o <= '0; in_I18o <= '0;
    end else begin
      opcode_ep <= OPC_NOP;
      opcode_op <= OPC_LNOP;
      if (iss_even) begin
        opcode_ep  <= ins_even.opcode;
        ra_addr_ep <= ins_even.ra;
        rb_addr_ep <= ins_even.rb;
        rc_addr_ep <= ins_even.rc;
        rt_addr_ep <= ins_even.rt;
        in_I7e     <= ins_even.i18[6:0];
        in_I8e     <= ins_even.i18[7:0];
        in_I10e    <= ins_even.i18[9:0];
        in_I16e    <= ins_even.i18[15:0];
        in_I18e    <= ins_even.i18;
      end
      if (iss_odd) begin
        opcode_op  <= ins_odd.opcode;
        ra_addr_op <= ins_odd.ra;
        rb_addr_op <= ins_odd.rb;
        rc_addr_op <= ins_odd.rc;
        rt_addr_op <= ins_odd.rt;
        in_I7o     <= ins_odd.i18[6:0];
        in_I8o     <= ins_odd.i18[7:0];
        in_I10o    <= ins_odd.i18[9:0];
        in_I16o    <= ins_odd.i18[15:0];
        in_I18o    <= ins_odd.i18;
      end
    end
  end

`ifdef SPU_ISSUE_PERF_EN
  // Saturating counts of slot0 dependency stalls and of pairs split across cycles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
      split_cnt <= '0;
    end else begin
      if (state == PAIR && !ready0 && !flush && stall_cnt != '1)
        stall_cnt <= stall_cnt + 32'd1;
      if (state == SECOND && iss1 && split_cnt != '1)
        split_cnt <= split_cnt + 32'd1;
    end
  end
`else
  assign stall_cnt = '0;
  assign split_cnt = '0;
`endif

endmodule

// File: tb/tb_spu_dual_issue.sv
// Bench for spu_dual_issue: directed pairs, a timing-level model and literal spot checks.
module tb_spu_dual_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [56:0] in_ins0, in_ins1;
  logic        flush;
  logic [10:0] opcode_ep, opcode_op;
  logic [6:0]  ra_addr_ep, rb_addr_ep, rc_addr_ep, rt_addr_ep;
  logic [6:0]  ra_addr_op, rb_addr_op, rc_addr_op, rt_addr_op;
  logic [6:0]  in_I7e, in_I7o;
  logic [7:0]  in_I8e, in_I8o;
  logic [9:0]  in_I10e, in_I10o;
  logic [15:0] in_I16e, in_I16o;
  logic [17:0] in_I18e, in_I18o;
  logic [31:0] stall_cnt, split_cnt;

  localparam logic [10:0] A = 11'h0C0, AND_ = 11'h0C1, SHL = 11'h05B, ROT = 11'h058;
  localparam logic [10:0] FA = 11'h2C4, LQD = 11'h1A0, STQD = 11'h120, BR = 11'h190;
  localparam logic [10:0] NOP = 11'h201, LNOP = 11'h001;

  spu_dual_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_ins0(in_ins0), .in_ins1(in_ins1), .flush(flush),
    .opcode_ep(opcode_ep), .opcode_op(opcode_op),
    .ra_addr_ep(ra_addr_ep), .rb_addr_ep(rb_addr_ep), .rc_addr_ep(rc_addr_ep), .rt_addr_ep(rt_addr_ep),
    .ra_addr_op(ra_addr_op), .rb_addr_op(rb_addr_op), .rc_addr_op(rc_addr_op), .rt_addr_op(rt_addr_op),
    .in_I7e(in_I7e), .in_I8e(in_I8e), .in_I10e(in_I10e), .in_I16e(in_I16e), .in_I18e(in_I18e),
    .in_I7o(in_I7o), .in_I8o(in_I8o), .in_I10o(in_I10o), .in_I16o(in_I16o), .in_I18o(in_I18o),
    .stall_cnt(stall_cnt), .split_cnt(split_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct {
    logic [10:0] opc;
    logic [17:0] imm;
    int          ra, rb, rc, rt;
  } mins_t;

  mins_t pend[$];
  int    avail [128];   // first cycle a reader of the register may issue
  int    cyc = 0;
  int    stall_m = 0, split_m = 0;
  bit    chk_en = 0;
  logic [10:0] e_opc_ep = NOP, e_opc_op = LNOP;
  mins_t e_ep, e_op;

  function automatic int m_lat(input logic [10:0] o);
    case (o)
      A, AND_:     return 2;
      SHL, ROT:    return 4;
      FA, 11'h2C6: return 6;
      LQD, STQD:   return 6;
      default:     return (o == BR || o == NOP || o == LNOP) ? 1 : 2;
    endcase
  endfunction

  function automatic bit m_odd(input logic [10:0] o);
    return (o == LQD || o == STQD || o == BR || o == LNOP);
  endfunction

  function automatic mins_t dec(input logic [56:0] w);
    mins_t m;
    m.opc = w[56:46]; m.imm = w[45:28];
    m.ra = int'(w[27:21]); m.rb = int'(w[20:14]); m.rc = int'(w[13:7]); m.rt = int'(w[6:0]);
    return m;
  endfunction

  function automatic logic [56:0] mk(input logic [10:0] o, input logic [6:0] ra, rb, rc, rt,
                                      input logic [17:0] imm);
    return {o, imm, ra, rb, rc, rt};
  endfunction

  function automatic bit rdy(input mins_t m, input int c);
    if (avail[m.ra] > c || avail[m.rb] > c || avail[m.rc] > c) return 0;
    if (avail[m.rt] - c > m_lat(m.opc) - 1) return 0;
    return 1;
  endfunction

  task automatic route(input mins_t m);
    if (m_odd(m.opc)) begin e_op = m; e_opc_op = m.opc; end
    else              begin e_ep = m; e_opc_ep = m.opc; end
  endtask

  task automatic model_step();
    mins_t p0, p1;
    bit i0, i1, exp_rdy;
    int n;
    cyc++;
    if (!rst) begin
      pend.delete();
      foreach (avail[r]) avail[r] = 0;
      e_opc_ep = NOP; e_opc_op = LNOP;
      e_ep = '{default: 0}; e_op = '{default: 0};
      stall_m = 0; split_m = 0;
      chk_en = 1;
      return;
    end
    e_opc_ep = NOP; e_opc_op = LNOP;
    if (flush) begin
      pend.delete();
      if (chk_en) chk("in_ready_flush", 32'(in_ready), 32'd0);
      return;
    end
    n = pend.size(); i0 = 0; i1 = 0;
    if (n == 2) begin
      p0 = pend[0]; p1 = pend[1];
      i0 = rdy(p0, cyc);
      if (!i0) stall_m++;
      i1 = i0 && (m_odd(p0.opc) != m_odd(p1.opc)) && rdy(p1, cyc) &&
           p1.ra != p0.rt && p1.rb != p0.rt && p1.rc != p0.rt && p1.rt != p0.rt;
    end else if (n == 1) begin
      p0 = pend[0];
      i0 = rdy(p0, cyc);
      if (i0) split_m++;
    end
    if (i0) route(p0);
    if (i1) route(p1);
    if (i0) avail[p0.rt] = cyc + m_lat(p0.opc);
    if (i1) avail[p1.rt] = cyc + m_lat(p1.opc);
    if (i1) pend.delete();
    else if (i0) void'(pend.pop_front());
    exp_rdy = (pend.size() == 0);
    if (chk_en) chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (in_valid && exp_rdy) begin
      pend.push_back(dec(in_ins0));
      pend.push_back(dec(in_ins1));
    end
  endtask

  // Compare registered outputs against the model every cycle, then advance the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("opcode_ep", 32'(opcode_ep), 32'(e_opc_ep));
      chk("opcode_op", 32'(opcode_op), 32'(e_opc_op));
      chk("ra_addr_ep", 32'(ra_addr_ep), e_ep.ra);
      chk("rb_addr_ep", 32'(rb_addr_ep), e_ep.rb);
      chk("rc_addr_ep", 32'(rc_addr_ep), e_ep.rc);
      chk("rt_addr_ep", 32'(rt_addr_ep), e_ep.rt);
      chk("ra_addr_op", 32'(ra_addr_op), e_op.ra);
      chk("rb_addr_op", 32'(rb_addr_op), e_op.rb);
      chk("rc_addr_op", 32'(rc_addr_op), e_op.rc);
      chk("rt_addr_op", 32'(rt_addr_op), e_op.rt);
      chk("I18e", 32'(in_I18e), 32'(e_ep.imm));
      chk("I16e", 32'(in_I16e), 32'(e_ep.imm[15:0]));
      chk("I10e", 32'(in_I10e), 32'(e_ep.imm[9:0]));
      chk("I8e",  32'(in_I8e),  32'(e_ep.imm[7:0]));
      chk("I7e",  32'(in_I7e),  32'(e_ep.imm[6:0]));
      chk("I18o", 32'(in_I18o), 32'(e_op.imm));
      chk("I16o", 32'(in_I16o), 32'(e_op.imm[15:0]));
      chk("I10o", 32'(in_I10o), 32'(e_op.imm[9:0]));
      chk("I8o",  32'(in_I8o),  32'(e_op.imm[7:0]));
      chk("I7o",  32'(in_I7o),  32'(e_op.imm[6:0]));
`ifdef SPU_ISSUE_PERF_EN
      chk("stall_cnt", stall_cnt, stall_m);
      chk("split_cnt", split_cnt, split_m);
`else
      chk("stall_cnt", stall_cnt, 32'd0);
      chk("split_cnt", split_cnt, 32'd0);
`endif
    end
    model_step();
  end

  // ---------------- stimulus ----------------
  task automatic send_pair(input logic [56:0] w0, input logic [56:0] w1);
    bit done = 0;
    in_ins0 = w0; in_ins1 = w1; in_valid = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (in_ready) done = 1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("pair_accepted", 32'(done), 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int k_found;
    rst = 1'b0; in_valid = 1'b0; flush = 1'b0; in_ins0 = '0; in_ins1 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_opcode_ep", 32'(opcode_ep), 32'h201);
    chk("reset_opcode_op", 32'(opcode_op), 32'h001);
    chk("reset_rt_addr_ep", 32'(rt_addr_ep), 32'd0);
    chk("reset_I18o", 32'(in_I18o), 32'd0);

    // independent pair dual-issues one cycle after acceptance; next pair follows back-to-back
    send_pair(mk(A, 1, 2, 0, 3, 18'h00012), mk(LQD, 10, 0, 0, 4, 18'h2ABCD));
    send_pair(mk(AND_, 3, 0, 0, 16, 18'h00001), mk(STQD, 11, 0, 0, 17, 18'h00002));
    chk("dual_opcode_ep", 32'(opcode_ep), 32'h0C0);
    chk("dual_rt_addr_ep", 32'(rt_addr_ep), 32'd3);
    chk("dual_opcode_op", 32'(opcode_op), 32'h1A0);
    chk("dual_rt_addr_op", 32'(rt_addr_op), 32'd4);
    chk("dual_I16o", 32'(in_I16o), 32'hABCD);
    chk("dual_I8o", 32'(in_I8o), 32'hCD);
    chk("dual_I7o", 32'(in_I7o), 32'h4D);
    idle(8);

    // two even ops split; consumer of FA's r6 waits the full FA latency
    send_pair(mk(A, 1, 0, 0, 5, 18'h00003), mk(FA, 2, 0, 0, 6, 18'h00004));
    send_pair(mk(A, 6, 0, 0, 7, 18'h00005), mk(BR, 1, 0, 0, 8, 18'h00006));
    chk("split_fa_ep", 32'(opcode_ep), 32'h2C4);
    chk("split_fa_op", 32'(opcode_op), 32'h001);
    k_found = -1;
    for (int k = 1; k <= 20 && k_found < 0; k++) begin
      @(posedge clk); #2;
      if (opcode_ep == A && rt_addr_ep == 7'd7) k_found = k;
    end
    chk("dep_latency_fa", 32'(k_found), 32'd6);
    idle(8);

    // intra-pair RAW across pipes: split, slot1 issues at producer latency
    send_pair(mk(A, 1, 0, 0, 9, 18'h00007), mk(LQD, 9, 0, 0, 11, 18'h00008));
    @(posedge clk); #1;
    chk("raw_s0_ep", 32'(opcode_ep), 32'h0C0);
    chk("raw_s0_op", 32'(opcode_op), 32'h001);
    @(posedge clk); #1;
    chk("raw_wait_op", 32'(opcode_op), 32'h001);
    @(posedge clk); #1;
    chk("raw_s1_op", 32'(opcode_op), 32'h1A0);
    idle(8);

    // flush while slot1 waits; scoreboard keeps counting for the next reader of r13
    send_pair(mk(FA, 1, 0, 0, 13, 18'h00009), mk(LQD, 13, 0, 0, 14, 18'h0000A));
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_nop_ep", 32'(opcode_ep), 32'h201);
    chk("flush_nop_op", 32'(opcode_op), 32'h001);
    @(negedge clk);
    chk("flush_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send_pair(mk(A, 13, 0, 0, 15, 18'h0000B), mk(BR, 2, 0, 0, 18, 18'h0000C));
    idle(10);

    // write-after-write on r30 and a latency-4 intra-pair dependency
    send_pair(mk(FA, 1, 0, 0, 30, 18'h0000D), mk(BR, 2, 0, 0, 31, 18'h0000E));
    send_pair(mk(A, 1, 0, 0, 30, 18'h0000F), mk(LQD, 3, 0, 0, 32, 18'h00010));
    idle(10);
    send_pair(mk(SHL, 3, 0, 0, 40, 18'h3FFFF), mk(STQD, 40, 0, 0, 41, 18'h15555));
    send_pair(mk(ROT, 40, 0, 0, 42, 18'h00011), mk(AND_, 1, 0, 0, 43, 18'h00013));
    idle(12);

    // reset while a blocked pair is held
    send_pair(mk(FA, 1, 0, 0, 20, 18'h00014), mk(LQD, 2, 0, 0, 22, 18'h00015));
    send_pair(mk(A, 20, 0, 0, 23, 18'h00016), mk(BR, 1, 0, 0, 24, 18'h00017));
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_opcode_ep", 32'(opcode_ep), 32'h201);
    chk("midrst_opcode_op", 32'(opcode_op), 32'h001);
    chk("midrst_rt_addr_op", 32'(rt_addr_op), 32'd0);
    chk("midrst_I18e", 32'(in_I18e), 32'd0);
    @(negedge clk);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    idle(6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
